operand_fwd_ctrl: RTL and testbench

// - Forwarding/hazard controller feeding the 5:1 EX-stage operand muxes (one for rs1, one for rs2) of the pipelined RV32I core.
// - Decides the operand source while the consumer is still in ID, and registers the select into the ID/EX boundary.
// - Detects load-use hazards, stalls PC/IF-ID for one cycle and injects an EX bubble.
// - Counts stall cycles for performance monitoring.

---
 rtl/operand_fwd_ctrl_pkg.sv | 16 +
 rtl/operand_fwd_ctrl_fwd_src_pick.sv | 55 +++++
 rtl/operand_fwd_ctrl.sv | 138 +++++++++++++
 tb/tb_operand_fwd_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/operand_fwd_ctrl_pkg.sv
// Shared encodings for the EX-stage operand forwarding controller:
// operand mux select values and the load-use FSM state type.
package operand_fwd_ctrl_pkg;

   localparam logic [2:0] FWD_RF        = 3'b000;
   localparam logic [2:0] FWD_EXMEM_ALU = 3'b001;
   localparam logic [2:0] FWD_MEMWB_ALU = 3'b010;
   localparam logic [2:0] FWD_MEMWB_LD  = 3'b011;
   localparam logic [2:0] FWD_POSTWB    = 3'b100;

   typedef enum logic [0:0] {
      ST_RUN      = 1'b0,
      ST_LU_STALL = 1'b1
   } fsm_state_e;

endpackage

// File: rtl/operand_fwd_ctrl_fwd_src_pick.sv
// Per-operand priority match against the EX/MEM/WB producers; the select
// names where the producer will sit when the consumer reaches EX.
module fwd_src_pick
   import operand_fwd_ctrl_pkg::*;
#(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] rs_i,
   input  logic             rs_used_i,
   input  logic             ex_valid_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_regwrite_i,
   input  logic             ex_is_load_i,
   input  logic             mem_valid_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic             mem_regwrite_i,
   input  logic             mem_is_load_i,
   input  logic             wb_valid_i,
   input  logic [REG_W-1:0] wb_rd_i,
   input  logic             wb_regwrite_i,
   output logic [2:0]       sel_o,
   output logic             load_use_o
);

   logic rs_live_s;
   logic ex_hit_s;
   logic mem_hit_s;
   logic wb_hit_s;

   // x0 reads never forward, so a zero index disqualifies every producer
   assign rs_live_s = rs_used_i && (rs_i != {REG_W{1'b0}});
   assign ex_hit_s  = rs_live_s && ex_valid_i  && ex_regwrite_i  && (ex_rd_i  == rs_i);
   assign mem_hit_s = rs_live_s && mem_valid_i && mem_regwrite_i && (mem_rd_i == rs_i);
   assign wb_hit_s  = rs_live_s && wb_valid_i  && wb_regwrite_i  && (wb_rd_i  == rs_i);

   // Nearest producer wins
   always_comb begin
      sel_o      = FWD_RF;
      load_use_o = 1'b0;
      if (ex_hit_s) begin
         sel_o      = FWD_EXMEM_ALU;
         load_use_o = ex_is_load_i;
      end else if (mem_hit_s) begin
         sel_o      = mem_is_load_i ? FWD_MEMWB_LD : FWD_MEMWB_ALU;
         load_use_o = 1'b0;
      end else if (wb_hit_s) begin
         sel_o      = FWD_POSTWB;
         load_use_o = 1'b0;
      end else begin
         sel_o      = FWD_RF;
         load_use_o = 1'b0;
      end
   end

endmodule

// File: rtl/operand_fwd_ctrl.sv
// Forwarding/hazard controller: registers the rs1/rs2 operand selects into
// the ID/EX boundary, stalls one cycle on load-use and counts stall cycles.
module operand_fwd_ctrl
   import operand_fwd_ctrl_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold_i,
   input  logic             flush_i,
   input  logic             id_valid_i,
   input  logic [REG_W-1:0] id_rs1_i,
   input  logic [REG_W-1:0] id_rs2_i,
   input  logic             id_rs1_used_i,
   input  logic             id_rs2_used_i,
   input  logic             ex_valid_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             ex_regwrite_i,
   input  logic             ex_is_load_i,
   input  logic             mem_valid_i,
   input  logic [REG_W-1:0] mem_rd_i,
   input  logic             mem_regwrite_i,
   input  logic             mem_is_load_i,
   input  logic             wb_valid_i,
   input  logic [REG_W-1:0] wb_rd_i,
   input  logic             wb_regwrite_i,
   output logic [2:0]       fwd_sel_a_o,
   output logic [2:0]       fwd_sel_b_o,
   output logic             stall_o,
   output logic             bubble_o,
   output logic [CNT_W-1:0] stall_count_o
);

   fsm_state_e       state_q;
   logic [2:0]       sel_a_q;
   logic [2:0]       sel_b_q;
   logic             bubble_q;
   logic [CNT_W-1:0] stall_count_q;

   logic [2:0]       sel_a_s;
   logic [2:0]       sel_b_s;
   logic             lu_a_s;
   logic             lu_b_s;
   logic             hazard_s;
   logic             stall_s;

   fwd_src_pick #(.REG_W(REG_W)) u_pick_a (
      .rs_i           (id_rs1_i),
      .rs_used_i      (id_rs1_used_i),
      .ex_valid_i     (ex_valid_i),
      .ex_rd_i        (ex_rd_i),
      .ex_regwrite_i  (ex_regwrite_i),
      .ex_is_load_i   (ex_is_load_i),
      .mem_valid_i    (mem_valid_i),
      .mem_rd_i       (mem_rd_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_is_load_i  (mem_is_load_i),
      .wb_valid_i     (wb_valid_i),
      .wb_rd_i        (wb_rd_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .sel_o          (sel_a_s),
      .load_use_o     (lu_a_s)
   );

   fwd_src_pick #(.REG_W(REG_W)) u_pick_b (
      .rs_i           (id_rs2_i),
      .rs_used_i      (id_rs2_used_i),
      .ex_valid_i     (ex_valid_i),
      .ex_rd_i        (ex_rd_i),
      .ex_regwrite_i  (ex_regwrite_i),
      .ex_is_load_i   (ex_is_load_i),
      .mem_valid_i    (mem_valid_i),
      .mem_rd_i       (mem_rd_i),
      .mem_regwrite_i (mem_regwrite_i),
      .mem_is_load_i  (mem_is_load_i),
      .wb_valid_i     (wb_valid_i),
      .wb_rd_i        (wb_rd_i),
      .wb_regwrite_i  (wb_regwrite_i),
      .sel_o          (sel_b_s),
      .load_use_o     (lu_b_s)
   );

   // In LU_STALL the bubble sits in EX, so a second stall is never raised
   assign hazard_s = id_valid_i && (lu_a_s || lu_b_s) && (state_q == ST_RUN);
   assign stall_s  = rst_n && hazard_s && !hold_i && !flush_i;
   assign stall_o  = stall_s;

   // FSM, ID/EX selects, bubble flag and saturating stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         sel_a_q       <= FWD_RF;
         sel_b_q       <= FWD_RF;
         bubble_q      <= 1'b1;
         stall_count_q <= {CNT_W{1'b0}};
      end else if (hold_i) begin
         state_q       <= state_q;
      end else begin
         if (stall_s && !(&stall_count_q)) begin
            stall_count_q <= stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         case (state_q)
            ST_RUN, ST_LU_STALL: begin
               if (flush_i) begin
                  state_q  <= ST_RUN;
                  sel_a_q  <= FWD_RF;
                  sel_b_q  <= FWD_RF;
                  bubble_q <= 1'b1;
               end else if (stall_s) begin
                  state_q  <= ST_LU_STALL;
                  sel_a_q  <= FWD_RF;
                  sel_b_q  <= FWD_RF;
                  bubble_q <= 1'b1;
               end else begin
                  state_q  <= ST_RUN;
                  sel_a_q  <= sel_a_s;
                  sel_b_q  <= sel_b_s;
                  bubble_q <= !id_valid_i;
               end
            end
            default: begin
               state_q  <= ST_RUN;
               sel_a_q  <= FWD_RF;
               sel_b_q  <= FWD_RF;
               bubble_q <= 1'b1;
            end
         endcase
      end
   end

   assign fwd_sel_a_o   = sel_a_q;
   assign fwd_sel_b_o   = sel_b_q;
   assign bubble_o      = bubble_q;
   assign stall_count_o = stall_count_q;

endmodule

// File: tb/tb_operand_fwd_ctrl.sv
// Scoreboard bench for operand_fwd_ctrl: an independent behavioural model
// queues the expected ID/EX outputs each cycle and they are checked after the edge.
module tb_operand_fwd_ctrl;

   localparam int CNT_W = 2;
   localparam int REG_W = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hold_i = 1'b0, flush_i = 1'b0;
   logic id_valid_i = 1'b0;
   logic [REG_W-1:0] id_rs1_i = '0, id_rs2_i = '0;
   logic id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
   logic ex_valid_i = 1'b0, ex_regwrite_i = 1'b0, ex_is_load_i = 1'b0;
   logic [REG_W-1:0] ex_rd_i = '0;
   logic mem_valid_i = 1'b0, mem_regwrite_i = 1'b0, mem_is_load_i = 1'b0;
   logic [REG_W-1:0] mem_rd_i = '0;
   logic wb_valid_i = 1'b0, wb_regwrite_i = 1'b0;
   logic [REG_W-1:0] wb_rd_i = '0;
   logic [2:0] fwd_sel_a_o, fwd_sel_b_o;
   logic stall_o, bubble_o;
   logic [CNT_W-1:0] stall_count_o;

   operand_fwd_ctrl #(.CNT_W(CNT_W), .REG_W(REG_W)) dut (
      .clk(clk), .rst_n(rst_n), .hold_i(hold_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
      .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
      .ex_valid_i(ex_valid_i), .ex_rd_i(ex_rd_i), .ex_regwrite_i(ex_regwrite_i),
      .ex_is_load_i(ex_is_load_i), .mem_valid_i(mem_valid_i), .mem_rd_i(mem_rd_i),
      .mem_regwrite_i(mem_regwrite_i), .mem_is_load_i(mem_is_load_i),
      .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_regwrite_i(wb_regwrite_i),
      .fwd_sel_a_o(fwd_sel_a_o), .fwd_sel_b_o(fwd_sel_b_o), .stall_o(stall_o),
      .bubble_o(bubble_o), .stall_count_o(stall_count_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]       a;
      logic [2:0]       b;
      logic             bub;
      logic [CNT_W-1:0] cnt;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   failures = 0;

   logic [2:0]       m_a, m_b;
   logic             m_bub, m_st;
   logic [CNT_W-1:0] m_cnt;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [2:0] ref_sel(input logic [REG_W-1:0] rs, input logic used);
      if (!used || rs == 5'd0) return 3'b000;
      if (ex_valid_i && ex_regwrite_i && ex_rd_i == rs) return 3'b001;
      if (mem_valid_i && mem_regwrite_i && mem_rd_i == rs) return mem_is_load_i ? 3'b011 : 3'b010;
      if (wb_valid_i && wb_regwrite_i && wb_rd_i == rs) return 3'b100;
      return 3'b000;
   endfunction

   task automatic model_reset();
      m_a = 3'b000; m_b = 3'b000; m_bub = 1'b1; m_st = 1'b0; m_cnt = '0;
      sb_q.delete();
   endtask

   task automatic idle();
      hold_i = 1'b0; flush_i = 1'b0; id_valid_i = 1'b0;
      id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
      ex_valid_i = 1'b0; ex_rd_i = 5'd0; ex_regwrite_i = 1'b0; ex_is_load_i = 1'b0;
      mem_valid_i = 1'b0; mem_rd_i = 5'd0; mem_regwrite_i = 1'b0; mem_is_load_i = 1'b0;
      wb_valid_i = 1'b0; wb_rd_i = 5'd0; wb_regwrite_i = 1'b0;
   endtask

   task automatic id_read(input logic [REG_W-1:0] r1, input logic u1,
                          input logic [REG_W-1:0] r2, input logic u2);
      id_valid_i = 1'b1; id_rs1_i = r1; id_rs1_used_i = u1; id_rs2_i = r2; id_rs2_used_i = u2;
   endtask

   // One cycle: check stall_o, advance model, push, clock, pop and compare
   task automatic step(input string tag);
      logic hz, st;
      exp_t e, g;
      #1;
      hz = id_valid_i && !m_st && ex_valid_i && ex_regwrite_i && ex_is_load_i &&
           ex_rd_i != 5'd0 &&
           ((id_rs1_used_i && id_rs1_i == ex_rd_i) || (id_rs2_used_i && id_rs2_i == ex_rd_i));
      st = hz && !hold_i && !flush_i;
      check_val({tag, ".stall"}, {31'd0, stall_o}, {31'd0, st});
      if (!hold_i) begin
         if (st && m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 2'd1;
         if (flush_i || st) begin
            m_a = 3'b000; m_b = 3'b000; m_bub = 1'b1; m_st = st;
         end else begin
            m_a = ref_sel(id_rs1_i, id_rs1_used_i);
            m_b = ref_sel(id_rs2_i, id_rs2_used_i);
            m_bub = !id_valid_i; m_st = 1'b0;
         end
      end
      e.a = m_a; e.b = m_b; e.bub = m_bub; e.cnt = m_cnt;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         check_val({tag, ".sb_empty"}, 32'd1, 32'd0);
      end else begin
         g = sb_q.pop_front();
         check_val({tag, ".sel_a"}, {29'd0, fwd_sel_a_o}, {29'd0, g.a});
         check_val({tag, ".sel_b"}, {29'd0, fwd_sel_b_o}, {29'd0, g.b});
         check_val({tag, ".bubble"}, {31'd0, bubble_o}, {31'd0, g.bub});
         check_val({tag, ".count"}, {30'd0, stall_count_o}, {30'd0, g.cnt});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, ".sel_a"}, {29'd0, fwd_sel_a_o}, 32'd0);
      check_val({tag, ".sel_b"}, {29'd0, fwd_sel_b_o}, 32'd0);
      check_val({tag, ".bubble"}, {31'd0, bubble_o}, 32'd1);
      check_val({tag, ".count"}, {30'd0, stall_count_o}, 32'd0);
      check_val({tag, ".stall"}, {31'd0, stall_o}, 32'd0);
   endtask

   // Load x3 in EX with rs1=x3 in ID, then the load moves to MEM
   task automatic load_use_pair(input string tag);
      idle(); id_read(5'd3, 1'b1, 5'd0, 1'b0);
      ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_regwrite_i = 1'b1; ex_is_load_i = 1'b1;
      step({tag, ".hz"});
      idle(); id_read(5'd3, 1'b1, 5'd0, 1'b0);
      mem_valid_i = 1'b1; mem_rd_i = 5'd3; mem_regwrite_i = 1'b1; mem_is_load_i = 1'b1;
      step({tag, ".ld"});
   endtask

   initial begin
      idle(); model_reset();
      rst_n = 1'b0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;

      idle(); id_read(5'd5, 1'b1, 5'd0, 1'b0);
      ex_valid_i = 1'b1; ex_rd_i = 5'd5; ex_regwrite_i = 1'b1;
      step("ex_alu");

      idle(); id_read(5'd0, 1'b0, 5'd7, 1'b1);
      mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_regwrite_i = 1'b1; mem_is_load_i = 1'b1;
      step("mem_ld");

      idle(); id_read(5'd0, 1'b0, 5'd7, 1'b1);
      wb_valid_i = 1'b1; wb_rd_i = 5'd7; wb_regwrite_i = 1'b1;
      step("wb");

      idle(); id_read(5'd0, 1'b1, 5'd0, 1'b1);
      ex_valid_i = 1'b1; ex_regwrite_i = 1'b1; ex_is_load_i = 1'b1;
      mem_valid_i = 1'b1; mem_regwrite_i = 1'b1;
      wb_valid_i = 1'b1; wb_regwrite_i = 1'b1;
      step("x0");

      idle(); id_read(5'd9, 1'b1, 5'd9, 1'b1);
      ex_valid_i = 1'b1; ex_rd_i = 5'd9; ex_regwrite_i = 1'b1;
      mem_valid_i = 1'b1; mem_rd_i = 5'd9; mem_regwrite_i = 1'b1;
      step("ex_wins");

      load_use_pair("lu");

      idle(); id_read(5'd3, 1'b1, 5'd3, 1'b1);
      ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_regwrite_i = 1'b1; ex_is_load_i = 1'b1;
      flush_i = 1'b1;
      step("lu_flush");

      idle(); id_read(5'd1, 1'b1, 5'd2, 1'b1);
      ex_valid_i = 1'b1; ex_rd_i = 5'd1; ex_regwrite_i = 1'b1;
      step("pre_hold");
      idle(); id_read(5'd3, 1'b1, 5'd0, 1'b0);
      ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_regwrite_i = 1'b1; ex_is_load_i = 1'b1;
      hold_i = 1'b1;
      step("lu_hold");
      step("lu_hold2");

      idle(); id_read(5'd3, 1'b1, 5'd0, 1'b0);
      ex_valid_i = 1'b1; ex_rd_i = 5'd3; ex_regwrite_i = 1'b1; ex_is_load_i = 1'b1;
      step("lu_pre_rst");
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("rst_mid_stall");
      @(negedge clk); rst_n = 1'b1;
      step("lu_redetect");
      idle(); id_read(5'd3, 1'b1, 5'd0, 1'b0);
      mem_valid_i = 1'b1; mem_rd_i = 5'd3; mem_regwrite_i = 1'b1; mem_is_load_i = 1'b1;
      step("lu_redetect_ld");

      for (int i = 0; i < 4; i++) load_use_pair("sat");

      for (int i = 0; i < 40; i++) begin
         idle();
         id_valid_i = 1'($urandom_range(0, 1));
         id_rs1_i = 5'($urandom_range(0, 3)); id_rs1_used_i = 1'($urandom_range(0, 1));
         id_rs2_i = 5'($urandom_range(0, 3)); id_rs2_used_i = 1'($urandom_range(0, 1));
         ex_valid_i = 1'($urandom_range(0, 1)); ex_rd_i = 5'($urandom_range(0, 3));
         ex_regwrite_i = 1'($urandom_range(0, 1)); ex_is_load_i = 1'($urandom_range(0, 1));
         mem_valid_i = 1'($urandom_range(0, 1)); mem_rd_i = 5'($urandom_range(0, 3));
         mem_regwrite_i = 1'($urandom_range(0, 1)); mem_is_load_i = 1'($urandom_range(0, 1));
         wb_valid_i = 1'($urandom_range(0, 1)); wb_rd_i = 5'($urandom_range(0, 3));
         wb_regwrite_i = 1'($urandom_range(0, 1));
         hold_i = ($urandom_range(0, 7) == 0);
         flush_i = ($urandom_range(0, 7) == 0);
         step("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
